prg_dma_loader: RTL and testbench

- Upstream stage of the c64 top: takes a PRG image held in a byte-wide source ROM and writes it into C64 RAM through the expansion-port DMA interface (DMA, Ai, Di, RW).
- The first two PRG bytes are the little-endian load address; the remaining bytes are written one per phi2 cycle, but only in phi2 cycles where BA=1.
- Replaces ad-hoc load sequencing in benches; also usable on the FPGA top as a boot loader.

---
 rtl/prg_loader_pkg.sv | 19 +
 rtl/phi2_edge_det.sv | 21 ++
 rtl/prg_dma_loader.sv | 196 +++++++++++++++++++
 tb/tb_prg_dma_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prg_loader_pkg.sv
// Shared types for the PRG DMA loader.
// State encoding and PRG header size.
package prg_loader_pkg;

  localparam int PRG_HDR_BYTES = 2;

  typedef enum logic [3:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    REQ,
    FETCH,
    WAIT_SLOT,
    WRITE,
    RELEASE,
    DONE
  } state_t;

endpackage

// File: rtl/phi2_edge_det.sv
// phi2 edge detector; phi2 is clk-derived,
// so no synchroniser stage is needed.
module phi2_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic phi2,
  output logic rise,
  output logic fall
);

  logic phi2_q;

  always_ff @(posedge clk) begin
    if (!reset) phi2_q <= 1'b0;
    else        phi2_q <= phi2;
  end

  assign rise = phi2 & ~phi2_q;
  assign fall = ~phi2 & phi2_q;

endmodule

// File: rtl/prg_dma_loader.sv
// PRG image loader into C64 RAM over expansion-port DMA.
// Optional payload checksum: PRG_DMA_LOADER_CHECKSUM_EN.
module prg_dma_loader
  import prg_loader_pkg::*;
#(
  parameter int SRC_AW        = 13,
  parameter int ROM_LATENCY   = 1,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SRC_AW:0]   prg_len,
  output logic [SRC_AW-1:0] src_addr,
  output logic              src_en,
  input  logic [7:0]        src_data,
  input  logic              phi2,
  input  logic              BA,
  output logic              DMA,
  output logic [15:0]       dma_addr,
  output logic [7:0]        dma_data,
  output logic              dma_rw,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef PRG_DMA_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam int LW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY + 1) : 1;
  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [LW-1:0] LAT = LW'(ROM_LATENCY);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SRC_AW:0] MIN_LEN = (SRC_AW + 1)'(3);
  localparam logic [SRC_AW:0] HDR_LEN = (SRC_AW + 1)'(PRG_HDR_BYTES);

  state_t state, state_n;

  logic rise, fall;
  logic [LW-1:0] lat;
  logic [SW-1:0] settle;
  logic [SRC_AW:0] cnt, cnt_inc, pay_len;
  logic [SRC_AW-1:0] fetch_cur, fetch_nxt;
  logic lat_hit, last, short_len;

  phi2_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .phi2  (phi2),
    .rise  (rise),
    .fall  (fall)
  );

  assign cnt_inc   = cnt + 1'b1;
  assign pay_len   = prg_len - HDR_LEN;
  assign last      = (cnt_inc == pay_len);
  assign short_len = (prg_len < MIN_LEN);
  assign lat_hit   = (lat == LAT);
  assign fetch_cur = SRC_AW'(PRG_HDR_BYTES) + cnt[SRC_AW-1:0];
  assign fetch_nxt = SRC_AW'(PRG_HDR_BYTES) + cnt_inc[SRC_AW-1:0];

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (start && !short_len) state_n = HDR_LO;
      HDR_LO:    if (lat_hit) state_n = HDR_HI;
      HDR_HI:    if (lat_hit) state_n = REQ;
      REQ:       if (rise && settle == SET_LAST) state_n = FETCH;
      FETCH:     if (lat_hit) state_n = WAIT_SLOT;
      WAIT_SLOT: if (rise && BA) state_n = WRITE;
      WRITE:     if (fall) state_n = last ? RELEASE : FETCH;
      RELEASE:   if (fall) state_n = DONE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      DMA      <= 1'b0;
      dma_rw   <= 1'b1;
      dma_addr <= '0;
      dma_data <= '0;
      src_en   <= 1'b0;
      src_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
      lat      <= '0;
      settle   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (short_len) begin
              err <= 1'b1;
            end else begin
              busy     <= 1'b1;
              cnt      <= '0;
              src_addr <= '0;
              src_en   <= 1'b1;
              lat      <= '0;
            end
          end
        end
        HDR_LO: begin
          if (lat_hit) begin
            dma_addr[7:0] <= src_data;
            src_addr      <= SRC_AW'(1);
            lat           <= '0;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        HDR_HI: begin
          if (lat_hit) begin
            dma_addr[15:8] <= src_data;
            src_en         <= 1'b0;
            DMA            <= 1'b1;
            settle         <= '0;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        REQ: begin
          if (rise) begin
            if (settle == SET_LAST) begin
              src_addr <= fetch_cur;
              src_en   <= 1'b1;
              lat      <= '0;
            end else begin
              settle <= settle + 1'b1;
            end
          end
        end
        FETCH: begin
          if (lat_hit) begin
            dma_data <= src_data;
            src_en   <= 1'b0;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        WAIT_SLOT: begin
          if (rise && BA) dma_rw <= 1'b0;
        end
        WRITE: begin
          // BA is ignored here: a started write always completes
          if (fall) begin
            dma_rw   <= 1'b1;
            dma_addr <= dma_addr + 16'd1;
            cnt      <= cnt_inc;
            if (!last) begin
              src_addr <= fetch_nxt;
              src_en   <= 1'b1;
              lat      <= '0;
            end
          end
        end
        RELEASE: begin
          if (fall) begin
            DMA  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PRG_DMA_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset)
      checksum <= '0;
    else if (state == IDLE && start)
      checksum <= '0;
    else if (state == WRITE && fall)
      checksum <= checksum + dma_data;
  end
`endif

endmodule

// File: tb/tb_prg_dma_loader.sv
// Directed and random loads of prg_dma_loader,
// checked against a ROM-image write-list model.
module tb_prg_dma_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [13:0] prg_len = '0;
  logic [12:0] src_addr;
  logic src_en;
  logic [7:0] src_data = '0;
  logic phi2;
  logic BA;
  logic DMA;
  logic [15:0] dma_addr;
  logic [7:0] dma_data;
  logic dma_rw, busy, done, err;
`ifdef PRG_DMA_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int total = 0;
  int bad = 0;

  logic [2:0] pdiv = '0;
  logic ba_fix = 1'b1;
  logic ba_rand = 1'b0;
  logic ba_r = 1'b1;
  logic [7:0] rom [0:8191];

  prg_dma_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .prg_len  (prg_len),
    .src_addr (src_addr),
    .src_en   (src_en),
    .src_data (src_data),
    .phi2     (phi2),
    .BA       (BA),
    .DMA      (DMA),
    .dma_addr (dma_addr),
    .dma_data (dma_data),
    .dma_rw   (dma_rw),
    .busy     (busy),
    .done     (done),
    .err      (err)
`ifdef PRG_DMA_LOADER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  // phi2 is 1/8 of the dot clock, high for 4 clks
  always @(posedge clk) pdiv <= pdiv + 3'd1;
  assign phi2 = pdiv[2];

  always @(posedge clk) ba_r <= ($urandom_range(0, 9) < 7);
  assign BA = ba_rand ? ba_r : ba_fix;

  always @(posedge clk) if (src_en) src_data <= rom[src_addr];

  // bus monitor: records every write cycle seen on the DMA port
  logic p_phi2 = 1'b0, p_rw = 1'b1, p_dma = 1'b0, last_ba = 1'b0;
  int gr = 0, dr_gr = 0, done_n = 0, err_n = 0;
  int dma_seen = 0, busy_seen = 0, unstable = 0, low = 0;
  logic [15:0] cur_a = '0;
  logic [7:0] cur_d = '0;
  logic [15:0] wa[$];
  logic [7:0] wd[$];
  logic wba[$];
  int wr[$];
  int wl[$];

  always @(negedge clk) begin
    if (DMA && !p_dma) dr_gr <= gr;
    if (phi2 && !p_phi2) begin
      gr <= gr + 1;
      last_ba <= BA;
    end
    if (DMA && !dma_rw && p_rw) begin
      wa.push_back(dma_addr);
      wd.push_back(dma_data);
      wba.push_back(last_ba);
      wr.push_back(gr);
      cur_a <= dma_addr;
      cur_d <= dma_data;
      low <= 1;
    end else if (!dma_rw) begin
      low <= low + 1;
      if (dma_addr !== cur_a || dma_data !== cur_d) unstable <= unstable + 1;
    end
    if (dma_rw && !p_rw) wl.push_back(low);
    if (done) done_n <= done_n + 1;
    if (err) err_n <= err_n + 1;
    if (DMA) dma_seen <= dma_seen + 1;
    if (busy) busy_seen <= busy_seen + 1;
    p_phi2 <= phi2;
    p_rw <= dma_rw;
    p_dma <= DMA;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int len);
    @(posedge clk);
    #1;
    prg_len = 14'(len);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // expected writes: addr base+i (16-bit wrap), data rom[2+i]
  task automatic run(input string tag, input int len);
    int n0, d0, e0, ds0, bs0, u0, k, nw;
    logic [15:0] base, ea;
    logic [7:0] sum;
    n0 = wa.size();
    d0 = done_n;
    e0 = err_n;
    ds0 = dma_seen;
    bs0 = busy_seen;
    u0 = unstable;
    pulse_start(len);
    k = 0;
    while (done_n == d0 && err_n == e0 && k < 20000) begin
      @(posedge clk);
      k++;
    end
    chk({tag, "/finish"}, 32'(k < 20000), 1);
    repeat (3) @(posedge clk);
    #1;
    nw = wa.size() - n0;
    if (len < 3) begin
      chk({tag, "/err"}, err_n - e0, 1);
      chk({tag, "/done"}, done_n - d0, 0);
      chk({tag, "/writes"}, nw, 0);
      chk({tag, "/dma_seen"}, dma_seen - ds0, 0);
      chk({tag, "/busy_seen"}, busy_seen - bs0, 0);
    end else begin
      base = {rom[1], rom[0]};
      chk({tag, "/done"}, done_n - d0, 1);
      chk({tag, "/err"}, err_n - e0, 0);
      chk({tag, "/writes"}, nw, len - 2);
      if (nw > 0) chk({tag, "/settle"}, 32'((wr[n0] - dr_gr) >= 4), 1);
      sum = '0;
      for (int i = 0; i < nw && i < len - 2; i++) begin
        ea = base + 16'(i);
        chk($sformatf("%s/addr%0d", tag, i), wa[n0+i], ea);
        chk($sformatf("%s/data%0d", tag, i), wd[n0+i], rom[2+i]);
        chk($sformatf("%s/ba%0d", tag, i), wba[n0+i], 1);
        if (wl.size() > n0 + i)
          chk($sformatf("%s/wlen%0d", tag, i), wl[n0+i], 4);
        sum = sum + rom[2+i];
      end
      ea = base + 16'(len - 2);
      chk({tag, "/end_addr"}, dma_addr, ea);
      chk({tag, "/dma_off"}, DMA, 0);
      chk({tag, "/rw_idle"}, dma_rw, 1);
      chk({tag, "/busy_off"}, busy, 0);
`ifdef PRG_DMA_LOADER_CHECKSUM_EN
      chk({tag, "/checksum"}, checksum, sum);
`endif
    end
    chk({tag, "/stable"}, unstable - u0, 0);
  endtask

  task automatic set_img(input logic [15:0] base, input int len);
    rom[0] = base[7:0];
    rom[1] = base[15:8];
    for (int i = 2; i < len; i++) rom[i] = 8'($urandom);
  endtask

  initial begin
    int n0, k, tgt;
    for (int i = 0; i < 8192; i++) rom[i] = 8'($urandom);

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/DMA", DMA, 0);
    chk("rst/rw", dma_rw, 1);
    chk("rst/addr", dma_addr, 0);
    chk("rst/data", dma_data, 0);
    chk("rst/src_en", src_en, 0);
    chk("rst/src_addr", src_addr, 0);
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    chk("rst/err", err, 0);
    reset = 1'b1;

    rom[0] = 8'h01; rom[1] = 8'h08;
    rom[2] = 8'hAA; rom[3] = 8'hBB; rom[4] = 8'hCC;
    run("basic", 5);
`ifdef PRG_DMA_LOADER_CHECKSUM_EN
    chk("basic/sum31", checksum, 8'h31);
`endif

    n0 = wa.size();
    fork
      run("ba_gap", 5);
      begin
        k = 0;
        while (wa.size() <= n0 && k < 5000) begin
          @(posedge clk);
          k++;
        end
        ba_fix = 1'b0;
        tgt = gr + 5;
        k = 0;
        while (gr < tgt && k < 5000) begin
          @(posedge clk);
          k++;
        end
        #2;
        ba_fix = 1'b1;
      end
    join
    if (wr.size() > n0 + 1)
      chk("ba_gap/rise_gap", wr[n0+1] - wr[n0], 6);
    else
      chk("ba_gap/rise_gap", 0, 6);

    run("short", 2);

    rom[0] = 8'hFF; rom[1] = 8'hFF;
    rom[2] = 8'h11; rom[3] = 8'h22;
    run("wrap", 4);

    rom[0] = 8'h01; rom[1] = 8'h08;
    rom[2] = 8'hAA; rom[3] = 8'hBB; rom[4] = 8'hCC;
    n0 = wa.size();
    fork
      run("busy_start", 5);
      begin
        k = 0;
        while (wa.size() <= n0 && k < 5000) begin
          @(posedge clk);
          k++;
        end
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join

    set_img(16'hC000, 10);
    n0 = wa.size();
    pulse_start(10);
    k = 0;
    while (wa.size() < n0 + 2 && k < 5000) begin
      @(posedge clk);
      k++;
    end
    chk("abort/reach", 32'(k < 5000), 1);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort/DMA", DMA, 0);
    chk("abort/rw", dma_rw, 1);
    chk("abort/busy", busy, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    run("reload", 10);

    ba_rand = 1'b1;
    for (int t = 0; t < 6; t++) begin
      int len;
      len = $urandom_range(3, 24);
      set_img(16'($urandom), len);
      run($sformatf("rnd%0d", t), len);
    end
    ba_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
